// File: rtl/mip_trilinear_blend_if.sv
// mip_trilinear_blend_if
//   Bundles the four handshakes of the trilinear blend stage.
//   Parameters: LW   - mip level index width
//               TAGW - request tag width
//   Signals:
//     req_*   - LOD request in (valid/ready, lod_int, lod_frac, tag)
//     fetch_* - texel fetch request out (valid/ready, level)
//     resp_*  - texel response in (valid, texel); no backpressure
//     out_*   - blended result out (valid/ready, texel, tag)
//   Modports: slave  - the blend block
//             master - the surrounding environment (LOD calc, texel cache, consumer)
interface mip_trilinear_blend_if #(
  parameter int LW   = 4,
  parameter int TAGW = 8
);
  logic            req_valid;
  logic            req_ready;
  logic [LW-1:0]   req_lod_int;
  logic [7:0]      req_lod_frac;
  logic [TAGW-1:0] req_tag;

  logic            fetch_valid;
  logic            fetch_ready;
  logic [LW-1:0]   fetch_level;

  logic            resp_valid;
  logic [31:0]     resp_texel;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_texel;
  logic [TAGW-1:0] out_tag;

  modport slave (
    input  req_valid, req_lod_int, req_lod_frac, req_tag,
    input  fetch_ready, resp_valid, resp_texel, out_ready,
    output req_ready, fetch_valid, fetch_level,
    output out_valid, out_texel, out_tag
  );

  modport master (
    output req_valid, req_lod_int, req_lod_frac, req_tag,
    output fetch_ready, resp_valid, resp_texel, out_ready,
    input  req_ready, fetch_valid, fetch_level,
    input  out_valid, out_texel, out_tag
  );
endinterface

// File: rtl/mip_trilinear_blend.sv
// mip_trilinear_blend
//   Trilinear mip blend stage. Takes one LOD request at a time, fetches the
//   texel of level lod_int and, when the fractional LOD is non-zero and a
//   coarser level exists, the texel of level lod_int+1, then blends the two
//   per RGBA8 channel with weight lod_frac/256 on the coarser level.
//   Parameters: LEVELS - number of mip levels (level index width = clog2)
//               TAGW   - request tag width
//   Ports: clk  - rising-edge clock
//          rst  - synchronous active-high reset
//          bus  - mip_trilinear_blend_if.slave (request, fetch, response,
//                 result handshakes)
//   Build option: MIP_TRILIN_ROUND_EN defined -> blend rounds half up
//                 (+128 before >>8); undefined -> blend truncates.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   S_IDLE   | ready for a request
//   S_FETCH0 | requesting texel of level lod_int
//   S_WAIT0  | waiting for level lod_int texel (c0)
//   S_FETCH1 | requesting texel of level lod_int+1 (dual only)
//   S_WAIT1  | waiting for level lod_int+1 texel (c1), then blend
//   S_OUT    | presenting result until consumer accepts
module mip_trilinear_blend #(
  parameter int LEVELS = 12,
  parameter int TAGW   = 8
) (
  input logic                clk,
  input logic                rst,
  mip_trilinear_blend_if.slave bus
);
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam logic [LW-1:0] LOD_MAX = LW'(LEVELS - 1);

`ifdef MIP_TRILIN_ROUND_EN
  localparam logic [16:0] RND = 17'd128;
`else
  localparam logic [16:0] RND = 17'd0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_WAIT0,
    S_FETCH1,
    S_WAIT1,
    S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lod_q, lod_d;
  logic [7:0]      frac_q, frac_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic            dual_q, dual_d;
  logic [31:0]     c0_q, c0_d;
  logic [31:0]     texel_q, texel_d;

  logic [LW-1:0]   lod_clamp;
  logic [31:0]     blend;

  // 17 bits hold 255*256 + 128 without overflow.
  function automatic logic [7:0] blend_ch(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [7:0] f);
    logic [16:0] w0;
    logic [16:0] sum;
    w0  = 17'd256 - {9'd0, f};
    sum = ({9'd0, a} * w0) + ({9'd0, b} * {9'd0, f}) + RND;
    return 8'(sum >> 8);
  endfunction

  assign lod_clamp = (bus.req_lod_int > LOD_MAX) ? LOD_MAX : bus.req_lod_int;

  always_comb begin
    blend = '0;
    for (int ch = 0; ch < 4; ch++) begin
      blend[8*ch +: 8] = blend_ch(c0_q[8*ch +: 8], bus.resp_texel[8*ch +: 8], frac_q);
    end
  end

  always_comb begin
    state_d = state_q;
    lod_d   = lod_q;
    frac_d  = frac_q;
    tag_d   = tag_q;
    dual_d  = dual_q;
    c0_d    = c0_q;
    texel_d = texel_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          lod_d   = lod_clamp;
          frac_d  = bus.req_lod_frac;
          tag_d   = bus.req_tag;
          // The finest-to-coarsest pair does not exist at the last level.
          dual_d  = (bus.req_lod_frac != 8'd0) && (lod_clamp != LOD_MAX);
          state_d = S_FETCH0;
        end
      end
      S_FETCH0: begin
        if (bus.fetch_ready) state_d = S_WAIT0;
      end
      S_WAIT0: begin
        if (bus.resp_valid) begin
          c0_d = bus.resp_texel;
          if (dual_q) begin
            state_d = S_FETCH1;
          end else begin
            texel_d = bus.resp_texel;
            state_d = S_OUT;
          end
        end
      end
      S_FETCH1: begin
        if (bus.fetch_ready) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (bus.resp_valid) begin
          texel_d = blend;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lod_q   <= '0;
      frac_q  <= '0;
      tag_q   <= '0;
      dual_q  <= 1'b0;
      c0_q    <= '0;
      texel_q <= '0;
    end else begin
      state_q <= state_d;
      lod_q   <= lod_d;
      frac_q  <= frac_d;
      tag_q   <= tag_d;
      dual_q  <= dual_d;
      c0_q    <= c0_d;
      texel_q <= texel_d;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.fetch_valid = (state_q == S_FETCH0) || (state_q == S_FETCH1);
  assign bus.fetch_level = (state_q == S_FETCH1) ? lod_q + LW'(1) :
                           (state_q == S_FETCH0) ? lod_q : '0;
  assign bus.out_valid   = (state_q == S_OUT);
  assign bus.out_texel   = texel_q;
  assign bus.out_tag     = tag_q;

endmodule

// File: tb/tb_mip_trilinear_blend.sv
module tb_mip_trilinear_blend;
  localparam int LEVELS = 12;
  localparam int LW     = 4;
  localparam int TAGW   = 8;

`ifdef MIP_TRILIN_ROUND_EN
  localparam int          RND      = 128;
  localparam logic [31:0] HALF_EXP = 32'h80808080;
`else
  localparam int          RND      = 0;
  localparam logic [31:0] HALF_EXP = 32'h7F7F7F7F;
`endif

  logic clk = 1'b0;
  logic rst;

  int n_vec   = 0;
  int n_err   = 0;
  int n_fetch = 0;
  int f0      = 0;
  int rsp_wait = -1;
  logic [31:0] rsp_cur = '0;
  logic [39:0] mon_e;

  logic [LW-1:0]   exp_lvl[$];
  logic [31:0]     rsp_q[$];
  int              dly_q[$];
  logic [39:0]     exp_out[$];

  logic [LW-1:0]   lod_r;
  logic [7:0]      frac_r;
  logic [31:0]     a_r, b_r, bp_exp;
  logic [TAGW-1:0] tag_r;
  bit              ok;

  mip_trilinear_blend_if #(.LW(LW), .TAGW(TAGW)) bus ();

  mip_trilinear_blend #(.LEVELS(LEVELS), .TAGW(TAGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [7:0] f);
    logic [31:0] r;
    int v;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      v = int'(a[8*k +: 8]) * (256 - int'(f)) + int'(b[8*k +: 8]) * int'(f) + RND;
      r[8*k +: 8] = 8'(v >> 8);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input bit cond);
    n_vec++;
    assert (cond) else begin
      n_err++;
      $error("FAIL %s: observed no-event expected event", tag);
    end
  endtask

  task automatic send(input logic [LW-1:0] lod, input logic [7:0] frac,
                      input logic [TAGW-1:0] tag);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.req_lod_int  = lod;
    bus.req_lod_frac = frac;
    bus.req_tag      = tag;
    bus.req_valid    = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (bus.req_ready === 1'b1) && !rst;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk_true("req_accept", got);
  endtask

  task automatic latency(input string tag, input int exp);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      seen = (bus.out_valid === 1'b1);
    end
    chk(tag, 64'(lat), 64'(exp));
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk); #1;
      done = (exp_out.size() == 0) && (bus.req_ready === 1'b1);
    end
    chk_true(tag, done);
  endtask

  task automatic push_fetch(input logic [LW-1:0] lvl, input logic [31:0] texel, input int dly);
    exp_lvl.push_back(lvl);
    rsp_q.push_back(texel);
    dly_q.push_back(dly);
  endtask

  initial begin
    rst               = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_lod_int   = '0;
    bus.req_lod_frac  = '0;
    bus.req_tag       = '0;
    bus.fetch_ready   = 1'b1;
    bus.out_ready     = 1'b1;
    bus.resp_valid    = 1'b0;
    bus.resp_texel    = '0;

    // Responder and scoreboard monitor.
    fork
      forever begin
        @(posedge clk); #1;
        bus.resp_valid = 1'b0;
        if (rsp_wait == 0) begin
          bus.resp_valid = 1'b1;
          bus.resp_texel = rsp_cur;
          rsp_wait = -1;
        end else if (rsp_wait > 0) begin
          rsp_wait--;
        end
        @(negedge clk);
        if (!rst && bus.fetch_valid === 1'b1 && bus.fetch_ready === 1'b1) begin
          n_fetch++;
          chk_true("fetch_expected", exp_lvl.size() != 0 && rsp_q.size() != 0);
          if (exp_lvl.size() != 0)
            chk("fetch_level", 64'(bus.fetch_level), 64'(exp_lvl.pop_front()));
          if (rsp_q.size() != 0) begin
            rsp_cur  = rsp_q.pop_front();
            rsp_wait = dly_q.pop_front();
          end
        end
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          chk_true("out_expected", exp_out.size() != 0);
          if (exp_out.size() != 0) begin
            mon_e = exp_out.pop_front();
            chk("out_texel", 64'(bus.out_texel), 64'(mon_e[31:0]));
            chk("out_tag", 64'(bus.out_tag), 64'(mon_e[39:32]));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_fetch_valid", 64'(bus.fetch_valid), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_fetch_level", 64'(bus.fetch_level), 64'(0));
    chk("rst_out_texel", 64'(bus.out_texel), 64'(0));
    chk("rst_out_tag", 64'(bus.out_tag), 64'(0));

    // Single fetch, minimum latency.
    push_fetch(4'd3, 32'h11223344, 0);
    exp_out.push_back({8'hA5, 32'h11223344});
    f0 = n_fetch;
    send(4'd3, 8'h00, 8'hA5);
    latency("lat_single", 3);
    drain("single_drain");
    chk("single_fetches", 64'(n_fetch - f0), 64'(1));

    // Dual fetch, half weight.
    push_fetch(4'd2, 32'h00000000, 0);
    push_fetch(4'd3, 32'hFFFFFFFF, 0);
    exp_out.push_back({8'h3C, HALF_EXP});
    f0 = n_fetch;
    send(4'd2, 8'h80, 8'h3C);
    latency("lat_dual", 5);
    drain("dual_drain");
    chk("dual_fetches", 64'(n_fetch - f0), 64'(2));

    // Last level: single even with non-zero fraction.
    push_fetch(4'd11, 32'hDEADBEEF, 0);
    exp_out.push_back({8'h0B, 32'hDEADBEEF});
    f0 = n_fetch;
    send(4'd11, 8'hC0, 8'h0B);
    drain("clamp_drain");
    chk("clamp_fetches", 64'(n_fetch - f0), 64'(1));

    // Out-of-range lod_int clamps to the last level.
    push_fetch(4'd11, 32'hCAFEF00D, 0);
    exp_out.push_back({8'h0F, 32'hCAFEF00D});
    f0 = n_fetch;
    send(4'd15, 8'h10, 8'h0F);
    drain("clamp15_drain");
    chk("clamp15_fetches", 64'(n_fetch - f0), 64'(1));

    // Backpressure on both fetch and output.
    a_r    = 32'h10203040;
    b_r    = 32'hF0E0D0C0;
    bp_exp = model(a_r, b_r, 8'h33);
    push_fetch(4'd5, a_r, 0);
    push_fetch(4'd6, b_r, 0);
    exp_out.push_back({8'h77, bp_exp});
    bus.fetch_ready = 1'b0;
    bus.out_ready   = 1'b0;
    f0 = n_fetch;
    send(4'd5, 8'h33, 8'h77);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_fetch_valid", 64'(bus.fetch_valid), 64'(1));
      chk("bp_fetch_level", 64'(bus.fetch_level), 64'(5));
      chk("bp_req_ready", 64'(bus.req_ready), 64'(0));
    end
    chk("bp_no_fetch_yet", 64'(n_fetch - f0), 64'(0));
    @(posedge clk); #1 bus.fetch_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = (bus.out_valid === 1'b1);
    end
    chk_true("bp_out_seen", ok);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
      chk("bp_out_texel", 64'(bus.out_texel), 64'(bp_exp));
      chk("bp_out_tag", 64'(bus.out_tag), 64'(8'h77));
      chk("bp_req_ready_out", 64'(bus.req_ready), 64'(0));
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    drain("bp_drain");
    chk("bp_fetches", 64'(n_fetch - f0), 64'(2));

    // A few random dual requests.
    for (int k = 0; k < 3; k++) begin
      lod_r  = 4'($urandom_range(0, 10));
      frac_r = 8'($urandom_range(1, 255));
      a_r    = $urandom;
      b_r    = $urandom;
      tag_r  = 8'($urandom);
      push_fetch(lod_r, a_r, 0);
      push_fetch(4'(lod_r + 4'd1), b_r, 0);
      exp_out.push_back({tag_r, model(a_r, b_r, frac_r)});
      send(lod_r, frac_r, tag_r);
      drain("rand_drain");
    end

    // Reset while waiting for the second texel; its response lands in IDLE.
    push_fetch(4'd4, 32'h12345678, 0);
    push_fetch(4'd5, 32'h9ABCDEF0, 1);
    send(4'd4, 8'h99, 8'h5E);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (bus.fetch_valid === 1'b1) && (bus.fetch_level === 4'd5);
    end
    chk_true("rst_fetch1_seen", ok);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("mid_rst_fetch_valid", 64'(bus.fetch_valid), 64'(0));
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_fetch_level", 64'(bus.fetch_level), 64'(0));
    chk("mid_rst_out_texel", 64'(bus.out_texel), 64'(0));
    chk("mid_rst_out_tag", 64'(bus.out_tag), 64'(0));
    @(negedge clk);
    chk("late_resp_out_valid", 64'(bus.out_valid), 64'(0));
    chk("late_resp_fetch_valid", 64'(bus.fetch_valid), 64'(0));
    chk("late_resp_req_ready", 64'(bus.req_ready), 64'(1));
    chk("late_resp_out_texel", 64'(bus.out_texel), 64'(0));

    push_fetch(4'd1, 32'h40404040, 0);
    push_fetch(4'd2, 32'h80808080, 0);
    exp_out.push_back({8'h21, 32'h50505050});
    f0 = n_fetch;
    send(4'd1, 8'h40, 8'h21);
    drain("post_rst_drain");
    chk("post_rst_fetches", 64'(n_fetch - f0), 64'(2));

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
